// File: rtl/viterbi_frame_ctrl.sv
// Frame sequencer for a viterbi_decoder: feeds FRAME_LEN coded symbols plus TB_LEN zero
// flush symbols, then collects FRAME_LEN decoded bits with first/last markers.
module viterbi_frame_ctrl #(
   parameter int FRAME_LEN = 512,
   parameter int TB_LEN    = 32,
   parameter int TIMEOUT   = 4096
) (
   input  logic       clk,
   input  logic       RSTn,
   input  logic       start,
   input  logic       s_valid,
   output logic       s_ready,
   input  logic [1:0] s_sym,
   output logic       dec_in_valid,
   output logic [1:0] dec_in,
   input  logic       dec_out_valid,
   input  logic       dec_out,
   output logic       m_valid,
   output logic       m_bit,
   output logic       m_first,
   output logic       m_last,
   output logic       busy,
   output logic       frame_done,
   output logic       err_timeout,
   output logic       err_extra,
   output logic [1:0] dbg_state
);

   localparam int CW = $clog2(FRAME_LEN + 1);
   localparam int FW = $clog2(TB_LEN + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   localparam logic [CW-1:0] C_ONE  = CW'(1);
   localparam logic [CW-1:0] C_LAST = CW'(FRAME_LEN - 1);
   localparam logic [CW-1:0] C_FULL = CW'(FRAME_LEN);
   localparam logic [FW-1:0] F_ONE  = FW'(1);
   localparam logic [FW-1:0] F_LAST = FW'(TB_LEN - 1);
   localparam logic [FW-1:0] F_FULL = FW'(TB_LEN);
   localparam logic [TW-1:0] T_ONE  = TW'(1);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
   localparam logic [TW-1:0] T_FULL = TW'(TIMEOUT);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FEED  = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   state_t        r_state;
   logic [CW-1:0] r_in_cnt;
   logic [CW-1:0] r_out_cnt;
   logic [FW-1:0] r_flush_cnt;
   logic [TW-1:0] r_timer;
   logic          r_dec_in_valid;
   logic [1:0]    r_dec_in;
   logic          r_m_valid;
   logic          r_m_bit;
   logic          r_m_first;
   logic          r_m_last;
   logic          r_frame_done;
   logic          r_err_timeout;
   logic          r_err_extra;

   logic w_hs;
   logic w_win;

   // Upstream valid/ready: a symbol transfers on a rising edge where s_valid and s_ready are both high.
   assign w_hs  = (r_state == ST_FEED) && s_valid;
   assign w_win = (r_state != ST_IDLE) && (r_out_cnt != C_FULL);

   always_ff @(posedge clk or negedge RSTn) begin
      if (!RSTn) begin
         r_state        <= ST_IDLE;
         r_in_cnt       <= '0;
         r_out_cnt      <= '0;
         r_flush_cnt    <= '0;
         r_timer        <= '0;
         r_dec_in_valid <= 1'b0;
         r_dec_in       <= 2'b00;
         r_m_valid      <= 1'b0;
         r_m_bit        <= 1'b0;
         r_m_first      <= 1'b0;
         r_m_last       <= 1'b0;
         r_frame_done   <= 1'b0;
         r_err_timeout  <= 1'b0;
         r_err_extra    <= 1'b0;
      end else begin
         r_frame_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_dec_in_valid <= 1'b0;
               if (start) begin
                  r_state       <= ST_FEED;
                  r_in_cnt      <= '0;
                  r_out_cnt     <= '0;
                  r_flush_cnt   <= '0;
                  r_timer       <= '0;
                  r_err_timeout <= 1'b0;
                  r_err_extra   <= 1'b0;
               end
            end
            ST_FEED: begin
               r_dec_in_valid <= w_hs;
               if (w_hs) begin
                  r_dec_in <= s_sym;
                  if (r_in_cnt != C_FULL) begin
                     r_in_cnt <= r_in_cnt + C_ONE;
                  end
                  if (r_in_cnt == C_LAST) begin
                     r_state <= ST_FLUSH;
                  end
               end
            end
            ST_FLUSH: begin
               r_dec_in       <= 2'b00;
               r_dec_in_valid <= 1'b1;
               if (r_flush_cnt != F_FULL) begin
                  r_flush_cnt <= r_flush_cnt + F_ONE;
               end
               if (r_flush_cnt == F_LAST) begin
                  r_state <= ST_DRAIN;
                  r_timer <= '0;
               end
            end
            ST_DRAIN: begin
               r_dec_in_valid <= 1'b0;
               // Completion wins over timeout when both line up on the same cycle.
               if (r_out_cnt == C_FULL) begin
                  r_frame_done <= 1'b1;
                  r_state      <= ST_IDLE;
               end else if (r_timer == T_LAST) begin
                  r_timer       <= T_FULL;
                  r_err_timeout <= 1'b1;
                  r_state       <= ST_IDLE;
               end else begin
                  r_timer <= r_timer + T_ONE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase

         if (dec_out_valid && w_win) begin
            r_m_valid <= 1'b1;
            r_m_bit   <= dec_out;
            r_m_first <= (r_out_cnt == '0);
            r_m_last  <= (r_out_cnt == C_LAST);
            r_out_cnt <= r_out_cnt + C_ONE;
         end else begin
            r_m_valid <= 1'b0;
            r_m_first <= 1'b0;
            r_m_last  <= 1'b0;
         end

         // A stray bit coinciding with start still counts as stray.
         if (dec_out_valid && !w_win) begin
            r_err_extra <= 1'b1;
         end
      end
   end

   assign s_ready      = (r_state == ST_FEED);
   assign busy         = (r_state != ST_IDLE);
   assign dbg_state    = r_state;
   assign dec_in_valid = r_dec_in_valid;
   assign dec_in       = r_dec_in;
   assign m_valid      = r_m_valid;
   assign m_bit        = r_m_bit;
   assign m_first      = r_m_first;
   assign m_last       = r_m_last;
   assign frame_done   = r_frame_done;
   assign err_timeout  = r_err_timeout;
   assign err_extra    = r_err_extra;

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// Bench for viterbi_frame_ctrl: a behavioural decoder stand-in emits bit k (code bit1 of
// symbol k) once symbol k+TB_LEN is consumed; a scoreboard checks the decoded stream.
module tb_viterbi_frame_ctrl;

   localparam int FRAME_LEN = 512;
   localparam int TB_LEN    = 32;
   localparam int TIMEOUT   = 100;
   localparam int TOTAL     = FRAME_LEN + TB_LEN;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       start = 1'b0;
   logic       s_valid = 1'b0;
   logic [1:0] s_sym = 2'b00;
   logic       s_ready;
   logic       dec_in_valid;
   logic [1:0] dec_in;
   logic       dec_out_valid;
   logic       m_valid, m_bit, m_first, m_last;
   logic       busy, frame_done, err_timeout, err_extra;
   logic [1:0] dbg_state;

   logic       stray = 1'b0;
   logic       model_clr = 1'b0;
   logic       clr_stats = 1'b0;
   int         cur_f = 0;
   int         stop_after = FRAME_LEN;

   int checks = 0;
   int failures = 0;

   logic [2:0] exp_q[$];

   always #5 clk = ~clk;

   viterbi_frame_ctrl #(
      .FRAME_LEN(FRAME_LEN),
      .TB_LEN   (TB_LEN),
      .TIMEOUT  (TIMEOUT)
   ) dut (
      .clk          (clk),
      .RSTn         (rst_n),
      .start        (start),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .s_sym        (s_sym),
      .dec_in_valid (dec_in_valid),
      .dec_in       (dec_in),
      .dec_out_valid(dec_out_valid),
      .dec_out      (model_bit),
      .m_valid      (m_valid),
      .m_bit        (m_bit),
      .m_first      (m_first),
      .m_last       (m_last),
      .busy         (busy),
      .frame_done   (frame_done),
      .err_timeout  (err_timeout),
      .err_extra    (err_extra),
      .dbg_state    (dbg_state)
   );

   function automatic logic bit_of(input int f, input int i);
      int v;
      v = (i * 13 + f * 7 + (i >>> 3)) % 3;
      return (v == 0) ^ ((i % 11) == f);
   endfunction

   function automatic logic [1:0] sym_of(input int f, input int i);
      logic b, p;
      b = bit_of(f, i);
      p = (i == 0) ? 1'b0 : bit_of(f, i - 1);
      return {b, b ^ p};
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Decoder stand-in
   logic [1:0] sym_log [0:TOTAL-1];
   int         model_n = 0;
   int         sym_bad = 0;
   int         flush_bad = 0;
   logic       model_dv;
   logic       model_bit;

   assign dec_out_valid = model_dv | stray;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         model_dv  <= 1'b0;
         model_bit <= 1'b0;
         model_n   <= 0;
      end else if (model_clr) begin
         model_dv  <= 1'b0;
         model_n   <= 0;
         sym_bad   <= 0;
         flush_bad <= 0;
      end else begin
         model_dv <= 1'b0;
         if (dec_in_valid) begin
            if (model_n < TOTAL) sym_log[model_n] <= dec_in;
            if (model_n < FRAME_LEN) begin
               if (dec_in !== sym_of(cur_f, model_n)) sym_bad <= sym_bad + 1;
            end else if (dec_in !== 2'b00) begin
               flush_bad <= flush_bad + 1;
            end
            if (model_n >= TB_LEN && model_n < TOTAL && (model_n - TB_LEN) < stop_after) begin
               model_dv  <= 1'b1;
               model_bit <= sym_log[model_n - TB_LEN][1];
            end
            model_n <= model_n + 1;
         end
      end
   end

   // Monitor / scoreboard
   int hs_cnt = 0, run = 0, max_run = 0, drain_cyc = 0, done_cnt = 0, last_cnt = 0, mv_cnt = 0;

   initial begin
      logic [2:0] e;
      forever begin
         @(negedge clk);
         if (clr_stats) begin
            hs_cnt = 0; run = 0; max_run = 0; drain_cyc = 0;
            done_cnt = 0; last_cnt = 0; mv_cnt = 0;
         end else if (rst_n) begin
            if (s_valid && s_ready) hs_cnt++;
            if (dec_in_valid) begin
               run++;
               if (run > max_run) max_run = run;
            end else begin
               run = 0;
            end
            if (dbg_state == 2'd3) drain_cyc++;
            if (frame_done) done_cnt++;
            if (m_last) last_cnt++;
            if (m_valid) begin
               mv_cnt++;
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  chk("m_first_last_bit", {29'b0, m_first, m_last, m_bit}, {29'b0, e});
               end else begin
                  chk("m_valid_unexpected", {31'b0, m_valid}, 0);
               end
            end
         end
      end
   end

   // Driver tasks
   task automatic begin_frame(input int f, input int stop);
      cur_f = f;
      stop_after = stop;
      clr_stats = 1'b1;
      @(negedge clk);
      #1 clr_stats = 1'b0;
      @(posedge clk);
      #1 start = 1'b1; model_clr = 1'b1;
      @(posedge clk);
      #1 start = 1'b0; model_clr = 1'b0;
   endtask

   task automatic feed(input int f, input bit stall, input bit dbl_start, input int stop);
      int   i = 0;
      int   guard = 0;
      logic hs;
      bit   pulsed = 1'b0;
      while (i < FRAME_LEN && guard < 20000) begin
         s_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         s_sym   = sym_of(f, i);
         start   = dbl_start && (i == 100) && !pulsed;
         if (start) pulsed = 1'b1;
         @(negedge clk);
         hs = s_valid && s_ready;
         @(posedge clk);
         #1;
         if (hs) begin
            if (i < stop) exp_q.push_back({(i == 0), (i == FRAME_LEN - 1), bit_of(f, i)});
            i++;
         end
         guard++;
      end
      s_valid = 1'b0;
      start   = 1'b0;
      chk("symbols_accepted", i, FRAME_LEN);
      chk("s_ready_after_last", {31'b0, s_ready}, 0);
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (busy && n < budget);
      chk("idle_within_budget", {31'b0, busy}, 0);
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic check_good_frame(input string tag, input bit b2b);
      chk({tag, "_handshakes"}, hs_cnt, FRAME_LEN);
      chk({tag, "_dec_symbols"}, model_n, TOTAL);
      chk({tag, "_data_sym_bad"}, sym_bad, 0);
      chk({tag, "_flush_sym_bad"}, flush_bad, 0);
      if (b2b) chk({tag, "_valid_run"}, max_run, TOTAL);
      else     chk({tag, "_flush_run"}, int'(max_run >= TB_LEN + 1), 1);
      chk({tag, "_frame_done"}, done_cnt, 1);
      chk({tag, "_m_last"}, last_cnt, 1);
      chk({tag, "_bits_out"}, mv_cnt, FRAME_LEN);
      chk({tag, "_err_timeout"}, {31'b0, err_timeout}, 0);
      chk({tag, "_err_extra"}, {31'b0, err_extra}, 0);
      chk({tag, "_exp_q_empty"}, exp_q.size(), 0);
   endtask

   function automatic logic [13:0] all_outs();
      return {s_ready, dec_in_valid, dec_in, m_valid, m_bit, m_first, m_last,
              busy, frame_done, err_timeout, err_extra, dbg_state};
   endfunction

   initial begin
      #2 rst_n = 1'b0;
      #1 chk("reset_outputs_async", {18'b0, all_outs()}, 0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs_held", {18'b0, all_outs()}, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_after_reset", {18'b0, all_outs()}, 0);

      begin_frame(0, FRAME_LEN);
      feed(0, 1'b0, 1'b0, FRAME_LEN);
      wait_idle(1000);
      check_good_frame("b2b", 1'b1);

      begin_frame(1, FRAME_LEN);
      feed(1, 1'b1, 1'b0, FRAME_LEN);
      wait_idle(1000);
      check_good_frame("stall", 1'b0);

      begin_frame(2, FRAME_LEN);
      feed(2, 1'b0, 1'b1, FRAME_LEN);
      wait_idle(1000);
      check_good_frame("dbl_start", 1'b1);

      begin_frame(3, 300);
      feed(3, 1'b0, 1'b0, 300);
      wait_idle(2000);
      chk("to_err_timeout", {31'b0, err_timeout}, 1);
      chk("to_drain_cycles", drain_cyc, TIMEOUT);
      chk("to_state_idle", {30'b0, dbg_state}, 0);
      chk("to_no_frame_done", done_cnt, 0);
      chk("to_no_m_last", last_cnt, 0);
      chk("to_bits_out", mv_cnt, 300);
      chk("to_exp_q_empty", exp_q.size(), 0);

      @(posedge clk);
      #1 stray = 1'b1;
      @(posedge clk);
      #1 stray = 1'b0;
      @(negedge clk);
      chk("stray_err_extra", {31'b0, err_extra}, 1);
      chk("stray_m_valid", {31'b0, m_valid}, 0);
      chk("stray_busy", {31'b0, busy}, 0);

      begin_frame(4, FRAME_LEN);
      chk("start_clears_err_extra", {31'b0, err_extra}, 0);
      chk("start_clears_err_timeout", {31'b0, err_timeout}, 0);
      feed(4, 1'b0, 1'b0, FRAME_LEN);
      wait_idle(1000);
      check_good_frame("after_stray", 1'b1);

      begin_frame(5, FRAME_LEN);
      feed(5, 1'b0, 1'b0, FRAME_LEN);
      begin
         int n = 0;
         while (model_n < FRAME_LEN + 10 && n < 200) begin
            @(negedge clk);
            n++;
         end
         chk("reached_flush_10", int'(model_n >= FRAME_LEN + 10), 1);
      end
      #1 rst_n = 1'b0;
      #1 chk("midflush_reset_outputs", {18'b0, all_outs()}, 0);
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("midflush_no_frame_done", done_cnt, 0);
      chk("midflush_idle", {18'b0, all_outs()}, 0);

      begin_frame(6, FRAME_LEN);
      feed(6, 1'b0, 1'b0, FRAME_LEN);
      wait_idle(1000);
      check_good_frame("post_reset", 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      failures++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

endmodule
